// File: rtl/prog_mem_refill.sv
// Instruction-cache refill adapter: one line miss becomes one AXI4 INCR read burst,
// and the returned beats are assembled into a line with a sticky bus-error flag.
package prog_mem_refill_pkg;
    localparam int unsigned AddrW = 32;
    localparam int unsigned DataW = 64;
    localparam int unsigned IdW   = 2;
    localparam int unsigned UserW = 1;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [AddrW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic             lock;
        logic [3:0]       cache;
        logic [2:0]       prot;
        logic [3:0]       qos;
        logic [3:0]       region;
        logic [UserW-1:0] user;
    } ax_chan_t;

    typedef struct packed {
        logic [DataW-1:0]   data;
        logic [DataW/8-1:0] strb;
        logic               last;
        logic [UserW-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [1:0]       resp;
        logic [UserW-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdW-1:0]   id;
        logic [DataW-1:0] data;
        logic [1:0]       resp;
        logic             last;
        logic [UserW-1:0] user;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;
endpackage

module prog_mem_refill #(
    parameter int unsigned        AddrWidth = 32,
    parameter int unsigned        DataWidth = 64,
    parameter int unsigned        IdWidth   = 2,
    parameter int unsigned        UserWidth = 1,
    parameter int unsigned        LineWidth = 256,
    parameter logic [IdWidth-1:0] AxiId     = '0,
    parameter type                req_t     = prog_mem_refill_pkg::axi_req_t,
    parameter type                resp_t    = prog_mem_refill_pkg::axi_resp_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 refill_req_valid_i,
    output logic                 refill_req_ready_o,
    input  logic [AddrWidth-1:0] refill_req_addr_i,
    output logic                 refill_rsp_valid_o,
    input  logic                 refill_rsp_ready_i,
    output logic [LineWidth-1:0] refill_rsp_data_o,
    output logic                 refill_rsp_error_o,
    output req_t                 axi_req_o,
    input  resp_t                axi_resp_i
);
    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned OffW  = $clog2(LineWidth / 8);
    localparam logic [CntW-1:0]      LastBeat  = CntW'(Beats - 1);
    localparam logic [AddrWidth-1:0] AlignMask = ~((AddrWidth'(1) << OffW) - AddrWidth'(1));
    localparam logic [UserWidth-1:0] ArUser    = '0;

    typedef enum logic [1:0] {IDLE, AR, R, RSP} state_e;

    state_e                 state_q, state_d;
    logic [AddrWidth-1:0]   addr_q;
    logic [CntW-1:0]        cnt_q;
    logic [LineWidth-1:0]   line_q;
    logic                   err_q;
    logic                   ar_valid, r_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Handshake outputs are pure state decodes; only next-state looks at inputs.
    always_comb begin
        state_d            = state_q;
        refill_req_ready_o = 1'b0;
        refill_rsp_valid_o = 1'b0;
        ar_valid           = 1'b0;
        r_ready            = 1'b0;
        unique case (state_q)
            IDLE: begin
                refill_req_ready_o = 1'b1;
                if (refill_req_valid_i) state_d = AR;
            end
            AR: begin
                ar_valid = 1'b1;
                if (axi_resp_i.ar_ready) state_d = R;
            end
            R: begin
                r_ready = 1'b1;
                if (axi_resp_i.r_valid && cnt_q == LastBeat) state_d = RSP;
            end
            RSP: begin
                refill_rsp_valid_o = 1'b1;
                if (refill_rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        axi_req_o          = '0;
        axi_req_o.ar.id    = AxiId;
        axi_req_o.ar.addr  = addr_q;
        axi_req_o.ar.len   = 8'(Beats - 1);
        axi_req_o.ar.size  = 3'($clog2(DataWidth / 8));
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar.user  = ArUser;
        axi_req_o.ar_valid = ar_valid;
        axi_req_o.r_ready  = r_ready;
    end

    // Completion follows the beat count; a misplaced r.last only raises the error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            cnt_q  <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (refill_req_valid_i) begin
                    addr_q <= refill_req_addr_i & AlignMask;
                    err_q  <= 1'b0;
                end
                AR: if (axi_resp_i.ar_ready) cnt_q <= '0;
                R: if (axi_resp_i.r_valid) begin
                    line_q[cnt_q*DataWidth +: DataWidth] <= axi_resp_i.r.data;
                    cnt_q <= cnt_q + 1'b1;
                    if (axi_resp_i.r.resp[1] || (axi_resp_i.r.last != (cnt_q == LastBeat)))
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign refill_rsp_data_o  = line_q;
    assign refill_rsp_error_o = err_q;

    logic unused_resp;
    assign unused_resp = ^axi_resp_i;
endmodule

// File: doc/prog_mem_refill.md
Name: prog_mem_refill

Overview:
- Per-cluster instruction-refill adapter between a cluster's instruction-cache miss port and the shared program memory's cluster AXI slave port.
- Converts each single-line refill request into one AXI4 INCR read burst and assembles the returned beats into a full cache line.
- Returns the line, plus an error flag, on a valid/ready response channel.
- One refill outstanding at a time; read-only (AW/W/B unused).

Parameters:
- AddrWidth, 32, AXI and refill address width.
- DataWidth, 64, AXI data width (bits); power of two, >= 32.
- IdWidth, 2, AXI ID width.
- UserWidth, 1, AXI user width.
- LineWidth, 256, cache line width (bits); multiple of DataWidth; Beats = LineWidth/DataWidth, 1..256.
- AxiId, 0, constant ARID driven on every burst.
- req_t, logic, AXI request struct type (same AW/W/AR typedef family as the program memory port).
- resp_t, logic, AXI response struct type.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- refill_req_valid_i  in  1  refill request valid.
- refill_req_ready_o  out  1  refill request accepted.
- refill_req_addr_i  in  AddrWidth  byte address of the missing instruction (any alignment).
- refill_rsp_valid_o  out  1  line response valid.
- refill_rsp_ready_i  in  1  line response consumed.
- refill_rsp_data_o  out  LineWidth  assembled line.
- refill_rsp_error_o  out  1  bus error during the burst.
- axi_req_o  out  req_t  AXI master request toward the program memory.
- axi_resp_i  in  resp_t  AXI response from the program memory.

Behaviour:
- Reset (rst_i high, asynchronous):
  - state=IDLE; beat counter=0; line and error registers cleared.
  - refill_req_ready_o=1, refill_rsp_valid_o=0, refill_rsp_data_o=0, refill_rsp_error_o=0.
  - ar_valid=0, r_ready=0; aw_valid, w_valid and b_ready are always 0.
- FSM states: IDLE, AR, R, RSP.
- IDLE:
  - refill_req_ready_o=1.
  - On valid&ready: latch the address aligned down to the line (low log2(LineWidth/8) bits zeroed), clear the error flag, go to AR.
- AR:
  - ar_valid=1 with ar.addr=aligned address, ar.len=Beats-1, ar.size=log2(DataWidth/8), ar.burst=INCR, ar.id=AxiId.
  - ar.prot, ar.cache, ar.lock, ar.qos, ar.region, ar.user are all 0.
  - All AR fields are stable while ar_valid && !ar_ready.
  - On ar_ready: counter=0, go to R.
- R:
  - r_ready=1.
  - Each r_valid beat k is written to line bits [k*DataWidth +: DataWidth]; counter increments.
  - Error flag is set if r.resp[1]==1 (SLVERR/DECERR), or if r.last != (counter==Beats-1). The flag is sticky until the next request.
  - Termination is decided by the beat counter, not r.last. After beat Beats-1 is accepted, go to RSP.
- RSP:
  - refill_rsp_valid_o=1; data and error are held stable until refill_rsp_ready_i.
  - On handshake, go to IDLE.
- Latency with zero-wait slave:
  - request handshake cycle 0 -> ar_valid cycle 1.
  - First R beat accepted cycle 2 at the earliest (R beats cannot be accepted in the AR cycle).
  - refill_rsp_valid_o rises the cycle after the last beat.
  - The next request is accepted the cycle after the response handshake (one idle cycle minimum).
- Unrelated AXI R beats while not in R: r_ready=0, never consumed.
- Data and error outputs are registered; refill_req_ready_o, ar_valid and r_ready are decoded from state only (no combinational input-to-output paths).
- Reset mid-burst: immediate return to IDLE; any in-flight AXI transaction is abandoned (reset is system-wide, the slave is reset too).

Test Plan:
- Beats=4, req addr 0x1000_0014, zero-wait slave returning 0x11..,0x22..,0x33..,0x44.. -> ar.addr=0x1000_0000, len=3, size=3. Response data = {0x44..,0x33..,0x22..,0x11..} (beat 0 in LSBs), error=0, rsp_valid 6 cycles after request handshake (req cycle 0, AR 1, beats 2-5, rsp 6).
- ar_ready held low 5 cycles -> ar_valid and all AR fields stable throughout; burst completes normally with correct data.
- r_valid with 2-cycle gaps between beats, rsp_ready low for 10 cycles -> line correct; rsp_valid, data and error stable for the whole stall; req_ready=0 until the cycle after the handshake.
- Beat 2 with resp=SLVERR -> all 4 beats consumed, error=1. The next clean refill returns error=0.
- r.last asserted on beat 1 of 4 -> error=1, FSM still waits for 4 beats.
- rst_i pulsed during beat 2 -> outputs return to reset values asynchronously. A new request after reset runs a full correct refill.
